// File: rtl/conv_egress.sv
// conv_egress: AXI-Stream egress FIFO that absorbs un-throttleable kernel results and raises an early stall.
// Define CONV_EGRESS_PROTOCOL_CHECK_EN to build the res_* framing monitor that drives err_o.
module conv_egress #(
    parameter int DEPTH      = 16,
    parameter int SLACK      = 4,
    parameter int LINE_CNT_W = 16,
    parameter int PIXEL_W    = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  res_vld_i,
    input  logic [PIXEL_W-1:0]    res_data_i,
    input  logic                  res_sof_i,
    input  logic                  res_eol_i,
    output logic                  res_stall_o,
    output logic                  m_tvalid_o,
    output logic [PIXEL_W-1:0]    m_tdata_o,
    output logic                  m_tuser_o,
    output logic                  m_tlast_o,
    input  logic                  m_tready_i,
    output logic                  ovf_o,
    output logic [LINE_CNT_W-1:0] line_cnt_o,
    output logic                  err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [PIXEL_W-1:0] data;
        logic               sof;
        logic               eol;
    } beat_t;

    // Indexed with natural power-of-2 wrap; at most DEPTH-1 slots are ever occupied.
    beat_t          mem [DEPTH];
    beat_t          out_q;
    beat_t          in_beat;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count, count_nx, ram_cnt;
    logic           out_vld, pop, push, load, from_ram, bypass, ram_wr;

    always_comb begin
        in_beat  = '{data: res_data_i, sof: res_sof_i, eol: res_eol_i};
        pop      = out_vld & m_tready_i;
        push     = res_vld_i & ((count < CW'(DEPTH)) | pop);
        ram_cnt  = count - CW'(out_vld);
        load     = ~out_vld | pop;
        from_ram = load & (ram_cnt != '0);
        bypass   = load & (ram_cnt == '0) & push;
        ram_wr   = push & ~bypass;
        count_nx = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (ram_wr)
            mem[wr_ptr] <= in_beat;
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_vld     <= 1'b0;
            out_q       <= '0;
            res_stall_o <= 1'b0;
            ovf_o       <= 1'b0;
            line_cnt_o  <= '0;
        end else begin
            if (ram_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (from_ram) begin
                out_q  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end else if (bypass)
                out_q <= in_beat;
            out_vld     <= from_ram | bypass | (out_vld & ~pop);
            count       <= count_nx;
            res_stall_o <= count_nx >= CW'(DEPTH - SLACK);
            ovf_o       <= ovf_o | (res_vld_i & ~push);
            if (pop)
                line_cnt_o <= out_q.sof ? LINE_CNT_W'(out_q.eol) :
                              out_q.eol ? line_cnt_o + LINE_CNT_W'(1) : line_cnt_o;
        end
    end

    assign m_tvalid_o = out_vld;
    assign m_tdata_o  = out_q.data;
    assign m_tuser_o  = out_q.sof;
    assign m_tlast_o  = out_q.eol;

`ifdef CONV_EGRESS_PROTOCOL_CHECK_EN
    logic                  seen_sof, wid_vld, wid_ok, err_q;
    logic [LINE_CNT_W-1:0] pix_cnt, width, pix_n;

    // A SOF beat starts a new frame, so any width latched earlier no longer applies to it.
    always_comb begin
        pix_n  = (res_sof_i ? '0 : pix_cnt) + LINE_CNT_W'(1);
        wid_ok = wid_vld & ~res_sof_i;
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            seen_sof <= 1'b0;
            wid_vld  <= 1'b0;
            pix_cnt  <= '0;
            width    <= '0;
            err_q    <= 1'b0;
        end else if (res_vld_i) begin
            err_q    <= err_q | (~seen_sof & ~res_sof_i) | (res_sof_i & (pix_cnt != '0)) |
                        (res_eol_i & wid_ok & (pix_n != width));
            seen_sof <= seen_sof | res_sof_i;
            if (res_eol_i) begin
                pix_cnt <= '0;
                if (~wid_ok & (seen_sof | res_sof_i)) begin
                    width   <= pix_n;
                    wid_vld <= 1'b1;
                end
            end else begin
                pix_cnt <= pix_n;
                if (res_sof_i)
                    wid_vld <= 1'b0;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_conv_egress.sv
// tb_conv_egress: directed self-checking bench for conv_egress (DEPTH=16, SLACK=4, 8-bit pixels).
module tb_conv_egress;
    logic        clk = 1'b0;
    logic        arst_n, res_vld_i, res_sof_i, res_eol_i, m_tready_i;
    logic [7:0]  res_data_i;
    logic        res_stall_o, m_tvalid_o, m_tuser_o, m_tlast_o, ovf_o, err_o;
    logic [7:0]  m_tdata_o;
    logic [15:0] line_cnt_o;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  q[$];

    conv_egress dut (
        .clk(clk), .arst_n(arst_n), .res_vld_i(res_vld_i), .res_data_i(res_data_i),
        .res_sof_i(res_sof_i), .res_eol_i(res_eol_i), .res_stall_o(res_stall_o),
        .m_tvalid_o(m_tvalid_o), .m_tdata_o(m_tdata_o), .m_tuser_o(m_tuser_o),
        .m_tlast_o(m_tlast_o), .m_tready_i(m_tready_i), .ovf_o(ovf_o),
        .line_cnt_o(line_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic e);
        res_vld_i  = v;
        res_data_i = d;
        res_sof_i  = s;
        res_eol_i  = e;
    endtask

    initial begin
        logic       held;
        logic [9:0] hold_v;
        arst_n = 1'b0;
        m_tready_i = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        arst_n = 1'b1;

        // 1: reset in the middle of traffic discards held beats
        drive(1'b1, 8'h11, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        step();
        chk("pre_rst_tvalid", m_tvalid_o, 1);
        arst_n = 1'b0;
        step();
        step();
        chk("rst_tvalid", m_tvalid_o, 0);
        chk("rst_stall", res_stall_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_line_cnt", line_cnt_o, 0);
        chk("rst_tdata", {m_tdata_o, m_tuser_o, m_tlast_o}, 0);
        arst_n = 1'b1;
        m_tready_i = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("post_rst_tvalid", m_tvalid_o, 0);
        chk("post_rst_err", err_o, 0);

        // 2: bypass latency into an empty block
        drive(1'b1, 8'h5A, 1'b1, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("lat_tvalid", m_tvalid_o, 1);
        chk("lat_beat", {m_tdata_o, m_tuser_o, m_tlast_o}, {8'h5A, 2'b11});
        step();
        chk("lat_tvalid_drop", m_tvalid_o, 0);
        chk("lat_line_cnt", line_cnt_o, 1);

        // 3: fill, stall threshold, overflow drop, back-to-back drain
        m_tready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
            step();
            if (i == 10) chk("stall_at_11", res_stall_o, 0);
            if (i == 11) chk("stall_at_12", res_stall_o, 1);
        end
        chk("ovf_full", ovf_o, 0);
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_set", ovf_o, 1);
        m_tready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_tvalid", m_tvalid_o, 1);
            chk("drain_tdata", m_tdata_o, 8'h10 + 8'(i));
            step();
        end
        chk("drain_empty", m_tvalid_o, 0);
        chk("drain_stall", res_stall_o, 0);
        chk("ovf_sticky", ovf_o, 1);
        chk("fill_line_cnt", line_cnt_o, 1);

        // 4: ready toggling with continuous pushes; stability under back-pressure
        held = 1'b0;
        hold_v = '0;
        for (int k = 0; k < 16; k++) begin
            m_tready_i = (k % 2 == 0);
            drive(1'b1, 8'h40 + 8'(k), 1'b0, 1'b0);
            if (m_tvalid_o) begin
                if (held) chk("hold_stable", {m_tdata_o, m_tuser_o, m_tlast_o}, hold_v);
                if (m_tready_i) begin
                    chk("hold_order", m_tdata_o, q[0]);
                    void'(q.pop_front());
                end
            end
            held = m_tvalid_o & ~m_tready_i;
            hold_v = {m_tdata_o, m_tuser_o, m_tlast_o};
            q.push_back(res_data_i);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        m_tready_i = 1'b1;
        for (int n = 0; n < 40 && q.size() > 0; n++) begin
            chk("hold_drain_tvalid", m_tvalid_o, 1);
            chk("hold_drain_tdata", m_tdata_o, q[0]);
            void'(q.pop_front());
            step();
        end
        chk("hold_drain_done", q.size(), 0);
        chk("hold_empty", m_tvalid_o, 0);

        // 5: 4x3 frame then a new SOF
        m_tready_i = 1'b0;
        for (int b = 0; b < 12; b++) begin
            drive(1'b1, 8'h80 + 8'(b), b == 0, b % 4 == 3);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        m_tready_i = 1'b1;
        for (int b = 0; b < 12; b++) begin
            chk("frm_beat", {m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o},
                {1'b1, 8'h80 + 8'(b), b == 0, b % 4 == 3});
            step();
            chk("frm_line_cnt", line_cnt_o, (b + 1) / 4);
        end
        drive(1'b1, 8'hC0, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("sof2_beat", {m_tvalid_o, m_tdata_o, m_tuser_o}, {1'b1, 8'hC0, 1'b1});
        chk("sof2_line_cnt_before", line_cnt_o, 3);
        step();
        chk("sof2_line_cnt", line_cnt_o, 0);

`ifdef CONV_EGRESS_PROTOCOL_CHECK_EN
        // 6: short second line flags err_o without disturbing the stream
        arst_n = 1'b0;
        step();
        step();
        arst_n = 1'b1;
        chk("chk_err_rst", err_o, 0);
        for (int b = 0; b < 7; b++) begin
            drive(1'b1, 8'hA0 + 8'(b), b == 0, b == 3 || b == 6);
            step();
            chk("chk_beat", {m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o},
                {1'b1, 8'hA0 + 8'(b), b == 0, b == 3 || b == 6});
            chk("chk_err", err_o, b == 6);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        chk("chk_err_sticky", err_o, 1);
        chk("chk_line_cnt", line_cnt_o, 2);
`else
        chk("err_tied", err_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
